// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// Bit-level FSM encoding plus byte/word geometry and default line timing.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS                 = 8;
  localparam int BYTES_PER_WORD            = 4;
  localparam int DEFAULT_CLKS_PER_BIT      = 217;
  localparam int DEFAULT_IDLE_TIMEOUT_CLKS = 250000;

endpackage

// File: rtl/serial_byte_rx.sv
// 8N1 byte deserialiser: 2-FF synchroniser plus bit FSM; one byte or frame-error pulse per frame,
// issued the cycle after the mid-stop-bit sample. No back-pressure; the FSM is idle again mid stop bit.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err,
  output logic       rx_idle,
  output logic       start_det
);

  localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic          sync1_q;
  logic          sync2_q;
  rx_state_e     state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    data_q;
  logic          byte_vld_q;
  logic          frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx_serial;
      sync2_q     <= sync1_q;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!sync2_q) state_q <= ST_START;
        end
        ST_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            state_q   <= sync2_q ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            data_q    <= {sync2_q, data_q[7:1]};
            if (bit_idx_q == IDX_LAST) state_q <= ST_STOP;
            else                       bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            byte_vld_q  <= sync2_q;
            frame_err_q <= !sync2_q;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_byte   = data_q;
  assign byte_vld  = byte_vld_q;
  assign frame_err = frame_err_q;
  assign rx_idle   = (state_q == ST_IDLE);
  assign start_det = (state_q == ST_IDLE) && !sync2_q;

endmodule

// File: rtl/serial_word_rx.sv
// Packs four UART bytes (first byte in [31:24]) into a word with a one-cycle o_Rx_DV, one cycle after the
// byte pulse; an idle timeout discards partial words. No back-pressure: the word must be taken on the pulse.
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
  parameter int IDLE_TIMEOUT_CLKS = DEFAULT_IDLE_TIMEOUT_CLKS
) (
  input  logic        CLK_25MHZ,
  input  logic        RSTN,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [31:0] o_Rx_Four_Bytes,
  output logic        o_Frame_Err,
  output logic        o_Busy
);

  localparam int              TO_W    = $clog2(IDLE_TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT_CLKS - 1);
  localparam logic [1:0]      IDX_LAST = 2'(BYTES_PER_WORD - 1);

  logic [7:0] rx_byte;
  logic       byte_vld;
  logic       frame_err;
  logic       rx_idle;
  logic       start_det;

  serial_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (CLK_25MHZ),
    .rst       (RSTN),
    .rx_serial (i_Rx_Serial),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err),
    .rx_idle   (rx_idle),
    .start_det (start_det)
  );

  logic [1:0]      idx_q,    idx_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     word_q,   word_d;
  logic            dv_q,     dv_d;
  logic            ferr_q,   ferr_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expire;

  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    word_d    = word_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    to_cnt_d  = to_cnt_q;
    to_expire = rx_idle && (idx_q != 2'd0) && (to_cnt_q == TO_LAST);

    if (rx_idle && (idx_q != 2'd0)) to_cnt_d = to_cnt_q + TO_W'(1);
    if (start_det || (idx_q == 2'd0)) to_cnt_d = '0;

    // Expiry takes priority, so a start edge in the same cycle begins a fresh word.
    if (to_expire) begin
      idx_d    = 2'd0;
      to_cnt_d = '0;
    end else if (byte_vld) begin
      case (idx_q)
        2'd0:    shadow_d[31:24] = rx_byte;
        2'd1:    shadow_d[23:16] = rx_byte;
        2'd2:    shadow_d[15:8]  = rx_byte;
        default: shadow_d[7:0]   = rx_byte;
      endcase
      if (idx_q == IDX_LAST) begin
        word_d = {shadow_q[31:8], rx_byte};
        dv_d   = 1'b1;
        idx_d  = 2'd0;
      end else begin
        idx_d  = idx_q + 2'd1;
      end
    end else if (frame_err) begin
      ferr_d = 1'b1;
      idx_d  = 2'd0;
    end
  end

  always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
    if (RSTN) begin
      idx_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign o_Rx_DV         = dv_q;
  assign o_Rx_Four_Bytes = word_q;
  assign o_Frame_Err     = ferr_q;
  assign o_Busy          = !rx_idle || (idx_q != 2'd0);

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial receive front end for the chirp/tone controller. Deserialises 8N1 UART bytes from the host and packs every four consecutive bytes into one 32-bit word, presented with a single-cycle valid strobe. The word is the half-period count that the tone stage loads as its counter target. Adds two protections: an inter-byte timeout, so a dropped byte cannot permanently misalign word framing, and framing-error reporting.

## Interface
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200).
- IDLE_TIMEOUT_CLKS, 250000, idle clocks after a byte before a partial word is discarded (10 ms).
- CLK_25MHZ  in  1  system clock.
- RSTN  in  1  reset; asynchronous, active-high (despite the name).
- i_Rx_Serial  in  1  raw UART line, asynchronous, idles high.
- o_Rx_DV  out  1  one-cycle pulse: new word on o_Rx_Four_Bytes.
- o_Rx_Four_Bytes  out  32  last complete word; first received byte in [31:24].
- o_Frame_Err  out  1  one-cycle pulse on bad stop bit.
- o_Busy  out  1  high while a byte is in flight or a partial word is held.

## Operation
- **Input sync:** i_Rx_Serial passes through a 2-FF synchroniser. Both flops reset to 1.
- **Bit FSM states:** IDLE, START, DATA, STOP.
  - IDLE: a synchronised low moves to START; clock counter cleared.
  - START: wait CLKS_PER_BIT/2 (integer division), then sample. Low goes to DATA. High is a glitch: return to IDLE, no error.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit, LSB first, 8 bits. Bit index 0..7 and does not wrap.
  - STOP: sample at mid stop bit. 1 = byte valid. 0 = framing error. Either way, return to IDLE in the next cycle. No wait for the end of the stop bit.
- **Word assembly:**
  - Byte index 0..3. Byte n is written to bits [31-8n -: 8] of a shadow register.
  - Valid byte with index 3: copy shadow to o_Rx_Four_Bytes, pulse o_Rx_DV, reset index to 0.
  - Otherwise a valid byte increments the index.
- **Framing error:** pulse o_Frame_Err, discard the partial word (index to 0), leave o_Rx_Four_Bytes unchanged.
- **Timeout:**
  - The timeout counter runs only while index ≠ 0 and the bit FSM is in IDLE. It clears on every start-bit detection.
  - Reaching IDLE_TIMEOUT_CLKS resets index to 0 silently: no DV, no error.
  - The next byte then starts a fresh word.
- **Output hold:** o_Rx_Four_Bytes holds its value between words and is never partially updated.
- **o_Busy** = (FSM ≠ IDLE) or (index ≠ 0).

## Timing
- **Reset values:**
  - o_Rx_DV = 0, o_Frame_Err = 0, o_Busy = 0, o_Rx_Four_Bytes = 32'h0.
  - FSM = IDLE, index = 0, all counters = 0.
- **Mid-operation reset:** asserting RSTN mid-byte or mid-word discards everything immediately. The first post-reset word consists of four fresh bytes.
- **Latency:** from the pin falling edge of byte 3's start bit to the o_Rx_DV high cycle is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. The bench tolerance is ±2 cycles.
- **Pulse timing:**
  - o_Rx_DV and the new o_Rx_Four_Bytes value appear in the same cycle.
  - o_Rx_DV is exactly one cycle wide.
  - There is no back-pressure; the consumer must take the word on the pulse.
  - o_Rx_DV and o_Frame_Err are never high together.
- **Back-to-back bytes:** a start bit immediately following a stop bit (zero idle) must be accepted, because IDLE is re-entered mid stop bit.
- **Same-cycle conflict:** a start edge in the same cycle the timeout expires means the timeout wins. Index goes to 0, and the new byte becomes byte 0.

## Structure
- **Package `serial_rx_pkg`:** bit-FSM state enum, DATA_BITS = 8, BYTES_PER_WORD = 4, and the default CLKS_PER_BIT.
- **Sub-module `serial_byte_rx`:** synchroniser plus bit FSM. Outputs a byte, a byte-valid pulse and a frame-error pulse.
- **Top level:** holds the index, shadow register, timeout counter and output registers.

## Test plan
- Reset, then bytes 0x00, 0x0B, 0xEB, 0xC2 back-to-back → one o_Rx_DV pulse, o_Rx_Four_Bytes = 32'h000BEBC2, o_Frame_Err never high.
- Two words (0x12345678, then 0xDEADBEEF) with zero inter-byte gap → two DV pulses carrying the correct values, each checked against the latency formula ±2.
- Byte 1 sent with stop bit = 0 → o_Frame_Err pulse, no DV. The next four good bytes 0xAA, 0xBB, 0xCC, 0xDD → 32'hAABBCCDD.
- Send 2 bytes, idle IDLE_TIMEOUT_CLKS + 10 cycles, then 4 bytes 0x01..0x04 → single DV with 32'h01020304; the previous word is unchanged until then.
- 0.3·CLKS_PER_BIT low glitch on the line → no byte, no error, o_Busy returns to 0.
- RSTN pulse during byte 2 → all outputs 0. The following 4 bytes 0xCA, 0xFE, 0xF0, 0x0D → 32'hCAFEF00D.
